// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the NZCV flag bundle.
// The BUSY state exists only when ALU_MUL_EN is defined.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_RSVD = 3'b110,
      ALU_MUL  = 3'b111
   } alu_op_e;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} alu_state_e;
`else
   typedef enum logic [0:0] {StIdle, StDone} alu_state_e;
`endif

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } alu_flags_t;

endpackage

// File: rtl/param_seq_alu_if.sv
// Request/response bundle of the sequential ALU; the master drives requests and
// accepts results, the slave (the ALU) answers.
interface param_seq_alu_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic [ALU_OP_W-1:0] op;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    result;
   logic                flag_zero;
   logic                flag_negative;
   logic                flag_carry;
   logic                flag_overflow;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result,
      input  flag_zero, flag_negative, flag_carry, flag_overflow
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result,
      output flag_zero, flag_negative, flag_carry, flag_overflow
   );
endinterface

// File: rtl/param_seq_alu_seq_mul.sv
// seq_mul: shift-add unsigned multiplier, one multiplier bit per cycle, WIDTH cycles.
// done and product are valid together in the last step cycle (product = next accumulator).
module seq_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               busy_q, busy_d;

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start && !busy_q) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CntW'(WIDTH);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CntW'(1);
         if (cnt_q == CntW'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == CntW'(1));
   assign product = acc_step;

endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU with registered result and NZCV flags; single-cycle ops finish at the accept edge.
// Define ALU_MUL_EN to add the iterative multiplier (op 111); otherwise op 111 is reserved.
module param_seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic             clk,
   input logic             reset,
   param_seq_alu_if.slave  bus
);
   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   alu_flags_t       flags_q, flags_d;

   alu_op_e          op;
   logic             is_sub;
   logic [WIDTH-1:0] b_opnd;
   logic [WIDTH:0]   sum;
   logic             slt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;

   assign op = alu_op_e'(bus.op);

   // One adder for ADD and SUB: SUB is a + ~b + 1.
   assign is_sub = (op == ALU_SUB);
   assign b_opnd = is_sub ? ~bus.b : bus.b;
   assign sum    = {1'b0, bus.a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
   assign slt    = $signed(bus.a) < $signed(bus.b);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (bus.a[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         ALU_AND: alu_res = bus.a & bus.b;
         ALU_OR:  alu_res = bus.a | bus.b;
         ALU_XOR: alu_res = bus.a ^ bus.b;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   seq_mul #(
      .WIDTH (WIDTH)
   ) u_seq_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
`ifdef ALU_MUL_EN
               if (op == ALU_MUL) begin
                  mul_start = 1'b1;
                  state_d   = StBusy;
               end else
`endif
               begin
                  result_d = alu_res;
                  flags_d  = '{zero:     (alu_res == '0),
                               negative: alu_res[WIDTH-1],
                               carry:    alu_c,
                               overflow: alu_v};
                  state_d  = StDone;
               end
            end
         end
`ifdef ALU_MUL_EN
         StBusy: begin
            if (mul_done) begin
               result_d = mul_product[WIDTH-1:0];
               flags_d  = '{zero:     (mul_product[WIDTH-1:0] == '0),
                            negative: mul_product[WIDTH-1],
                            carry:    |mul_product[2*WIDTH-1:WIDTH],
                            overflow: 1'b0};
               state_d  = StDone;
            end else if (!mul_busy) begin
               // Multiplier lost its operation; never hang in BUSY.
               state_d = StIdle;
            end
         end
`endif
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.in_ready      = (state_q == StIdle);
   assign bus.out_valid     = (state_q == StDone);
   assign bus.result        = result_q;
   assign bus.flag_zero     = flags_q.zero;
   assign bus.flag_negative = flags_q.negative;
   assign bus.flag_carry    = flags_q.carry;
   assign bus.flag_overflow = flags_q.overflow;

endmodule

// File: tb/tb_param_seq_alu.sv
// Self-checking bench for param_seq_alu (WIDTH=8): directed table, random ops against an
// arithmetic model, and hand sequences for back-pressure and reset. Honours ALU_MUL_EN.
module tb_param_seq_alu;
   import alu_pkg::*;

   localparam int W = 8;
`ifdef ALU_MUL_EN
   localparam int MulLat = W + 1;
`else
   localparam int MulLat = 1;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   param_seq_alu_if #(.WIDTH(W)) bus ();

   param_seq_alu #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] fl;  // {Z,N,C,V}
      int         lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] get_fl();
      return {bus.flag_zero, bus.flag_negative, bus.flag_carry, bus.flag_overflow};
   endfunction

   // Reference: plain integer arithmetic on the op-code meanings.
   function automatic void model(input int op, input int a, input int b,
                                 output logic [7:0] res, output logic [3:0] fl, output int lat);
      int sa, sb, r, p;
      bit c, v;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      r = 0; c = 0; v = 0; lat = 1; p = 0;
      case (op)
         0: begin r = (a + b) & 255; c = (a + b) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
         1: begin r = (a - b) & 255; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (sa < sb) ? 1 : 0;
`ifdef ALU_MUL_EN
         7: begin p = a * b; r = p & 255; c = (p > 255); lat = MulLat; end
`endif
         default: r = 0;
      endcase
      res = r[7:0];
      fl  = {(r == 0), (r > 127), c, v};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("issue_in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.op = op;
      @(posedge clk);
      #1;
      // Scramble inputs after accept: they must have been captured.
      bus.in_valid = 1'b0;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
   endtask

   task automatic wait_valid(output int lat, output bit rdy_low);
      lat = 0;
      rdy_low = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (bus.in_ready) rdy_low = 1'b0;
      end while (!bus.out_valid && lat < 40);
   endtask

   task automatic ack(input int hold, output logic [7:0] res, output logic [3:0] fl,
                      output bit stable);
      res = bus.result;
      fl  = get_fl();
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (bus.result !== res || get_fl() !== fl || !bus.out_valid || bus.in_ready)
            stable = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input int hold, input logic [7:0] exp_res,
                            input logic [3:0] exp_fl, input int exp_lat);
      int         lat;
      bit         rdy_low, stable;
      logic [7:0] res;
      logic [3:0] fl;
      issue(op, a, b);
      wait_valid(lat, rdy_low);
      ack(hold, res, fl, stable);
      chk({name, "_result"}, {24'd0, res}, {24'd0, exp_res});
      chk({name, "_flags"}, {28'd0, fl}, {28'd0, exp_fl});
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_in_ready_low"}, {31'd0, rdy_low}, 32'd1);
      chk({name, "_stable"}, {31'd0, stable}, 32'd1);
   endtask

   task automatic check_after_reset(input string name);
      int pulses = 0;
      @(negedge clk);
      chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({name, "_result"}, {24'd0, bus.result}, 32'd0);
      chk({name, "_flags"}, {28'd0, get_fl()}, 32'd0);
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      chk({name, "_no_valid_pulse"}, pulses, 0);
   endtask

   vec_t vecs[13];

   initial begin
      logic [7:0] er;
      logic [3:0] ef;
      int         el, lat;
      bit         rdy_low, stable;
      logic [7:0] res;
      logic [3:0] fl;

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.op = '0;

      vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1};
      vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b1010, 1};
      vecs[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 4'b0100, 1};
      vecs[3]  = '{3'd5, 8'h80, 8'h01, 8'h01, 4'b0000, 1};
      vecs[4]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
      vecs[5]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 4'b0100, 1};
      vecs[6]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1};
      vecs[7]  = '{3'd6, 8'h12, 8'h34, 8'h00, 4'b1000, 1};
      vecs[8]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1};
      vecs[9]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0011, 1};
`ifdef ALU_MUL_EN
      vecs[10] = '{3'd7, 8'h03, 8'h04, 8'h0C, 4'b0000, MulLat};
      vecs[11] = '{3'd7, 8'h10, 8'h10, 8'h00, 4'b1010, MulLat};
      vecs[12] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0010, MulLat};
`else
      vecs[10] = '{3'd7, 8'h03, 8'h04, 8'h00, 4'b1000, 1};
      vecs[11] = '{3'd7, 8'h10, 8'h10, 8'h00, 4'b1000, 1};
      vecs[12] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 4'b1000, 1};
`endif

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_result", {24'd0, bus.result}, 32'd0);
      chk("reset_flags", {28'd0, get_fl()}, 32'd0);

      for (int i = 0; i < 13; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, i % 3,
                   vecs[i].res, vecs[i].fl, vecs[i].lat);
      end

      // SLT under back-pressure: result held, requests during DONE are dropped.
      begin
         bit hold_ok = 1'b1;
         issue(3'd5, 8'h80, 8'h01);
         wait_valid(lat, rdy_low);
         chk("slt_hold_latency", lat, 1);
         bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 8'h11; bus.b = 8'h22;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.result !== 8'h01 || !bus.out_valid || bus.in_ready) hold_ok = 1'b0;
         end
         chk("slt_hold_stable", {31'd0, hold_ok}, 32'd1);
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1 bus.out_ready = 1'b0;
         @(negedge clk);
         chk("slt_after_ack_in_ready", {31'd0, bus.in_ready}, 32'd1);
         chk("slt_after_ack_out_valid", {31'd0, bus.out_valid}, 32'd0);
         @(negedge clk);
         chk("slt_not_queued_valid", {31'd0, bus.out_valid}, 32'd0);
         chk("slt_not_queued_result", {24'd0, bus.result}, 32'h01);
      end

      // Reset while DONE: operation discarded.
      issue(3'd0, 8'h7F, 8'h01);
      wait_valid(lat, rdy_low);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check_after_reset("rst_done");

`ifdef ALU_MUL_EN
      // Reset in the 4th BUSY cycle of a multiply.
      run_check("pre_mul_add", 3'd0, 8'h01, 8'h01, 0, 8'h02, 4'b0000, 1);
      issue(3'd7, 8'h10, 8'h10);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check_after_reset("rst_busy");
`endif
      run_check("post_rst_add", 3'd0, 8'h02, 8'h03, 0, 8'h05, 4'b0000, 1);

      for (int i = 0; i < 150; i++) begin
         logic [2:0] op;
         logic [7:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         model(int'(op), int'(a), int'(b), er, ef, el);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, $urandom_range(0, 3), er, ef, el);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/op request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 op  input  3  operation code (see REQ-012).
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  registered result.
REQ-011 flag_zero, flag_negative, flag_carry, flag_overflow  output  1 each  registered NZCV flags.

Function
REQ-012 Op codes: 000 ADD, 001 SUB (a + ~b + 1), 010 AND, 011 OR, 100 XOR, 101 SLT (signed a<b -> 1, else 0), 110 reserved, 111 MUL (low WIDTH bits of unsigned a*b).
REQ-013 States IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-014 Accept occurs on an edge where in_valid && in_ready; a, b, op are captured at that edge and later input changes have no effect.
REQ-015 IDLE + accept of a non-MUL op -> DONE; result and flags are written at the accepting edge, so out_valid is high the next cycle (latency 1).
REQ-016 IDLE + accept of MUL -> BUSY; iterative shift-add, one bit per cycle, WIDTH cycles in BUSY, then DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-017 DONE: out_valid=1; result/flags held stable until the edge with out_ready=1, then -> IDLE.
REQ-018 in_valid outside IDLE: ignored, not queued; requester must hold until in_ready.
REQ-019 out_ready while not DONE: no effect.
REQ-020 Z = (result==0); N = result[WIDTH-1], for every op.
REQ-021 ADD: C = carry-out of bit WIDTH-1; V = operands same sign and result sign differs.
REQ-022 SUB: C = carry-out (1 means no borrow, a>=b unsigned); V = operand signs differ and result sign differs from a.
REQ-023 AND/OR/XOR/SLT/reserved: C=0, V=0.
REQ-024 MUL: C = 1 if upper WIDTH bits of the 2*WIDTH product are nonzero; V=0.
REQ-025 Reserved op: result 0, Z=1, latency 1.

Reset
REQ-026 On an edge with reset=1: state=IDLE, out_valid=0, result=0, all flags=0, multiplier accumulator cleared; in_ready=1 the following cycle.
REQ-027 Reset has priority over accept and completion; reset during BUSY or DONE discards the operation with no out_valid pulse.

Configuration
REQ-028 Macro ALU_MUL_EN: when defined, MUL behaves per REQ-016/REQ-024.
REQ-029 When ALU_MUL_EN is undefined, op 111 behaves as reserved (REQ-025), the BUSY state and multiplier logic are absent, and all ops have latency 1.

Structure
REQ-030 Package alu_pkg holds the op-code enum (ALU_ADD..ALU_MUL), the FSM state enum, and the constant ALU_OP_W=3.
REQ-031 Sub-module seq_mul (parametrised WIDTH; start/busy/done handshake; 2*WIDTH product output) implements the shift-add multiplier; it is instantiated only under ALU_MUL_EN.
REQ-032 ADD/SUB share one adder with b inverted and carry-in=1 for SUB.

Verification (WIDTH=8)
REQ-033 ADD 0x7F+0x01 -> result 0x80, N=1, V=1, C=0, Z=0, out_valid one cycle after accept.
REQ-034 SUB 0x05-0x05 -> 0x00, Z=1, C=1, V=0; SUB 0x03-0x05 -> 0xFE, N=1, C=0.
REQ-035 MUL 0x10*0x10 (ALU_MUL_EN) -> result 0x00, Z=1, C=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-036 SLT 0x80 vs 0x01 -> 0x01; out_ready held low 5 cycles -> result stable, in_ready=0, new in_valid ignored.
REQ-037 Reset asserted mid-MUL (cycle 4 of BUSY) -> no out_valid, outputs 0, in_ready=1 next cycle; following ADD 0x02+0x03 -> 0x05.
REQ-038 Without ALU_MUL_EN: op 111 with a=0x03, b=0x04 -> result 0x00, Z=1, latency 1.
